// File: rtl/rle_encoder_stream.sv
// Streaming run-length encoder: turns a symbol stream into (symbol, run length) pairs
// behind a single output register, closing runs on symbol change, saturation or frame end.
module rle_encoder_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int ZRL    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  m_count,
    output logic              m_last
);
    localparam logic [CNT_W-1:0] MAX_RUN = '1;

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   run_sym_q, run_sym_d;
    logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [CNT_W-1:0]    m_count_q, m_count_d;
    logic                m_last_q, m_last_d;

    logic                out_free;
    logic                accept;
    logic                merge;
    logic [CNT_W-1:0]    cnt_inc;
    logic                emit;
    logic [DATA_W-1:0]   emit_data;
    logic [CNT_W-1:0]    emit_count;
    logic                emit_last;

    assign out_free = !m_valid_q || m_ready;
    assign s_ready  = !rst && (state_q != PEND) && out_free;
    assign accept   = s_valid && s_ready;
    assign merge    = (s_data == run_sym_q) && ((ZRL == 0) || (s_data == '0));
    // A held run is always below MAX_RUN, so this increment cannot wrap.
    assign cnt_inc  = run_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        run_sym_d  = run_sym_q;
        run_cnt_d  = run_cnt_q;
        emit       = 1'b0;
        emit_data  = run_sym_q;
        emit_count = run_cnt_q;
        emit_last  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s_last) begin
                        emit       = 1'b1;
                        emit_data  = s_data;
                        emit_count = CNT_W'(1);
                        emit_last  = 1'b1;
                    end else begin
                        run_sym_d = s_data;
                        run_cnt_d = CNT_W'(1);
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (merge) begin
                        if ((cnt_inc == MAX_RUN) || s_last) begin
                            emit       = 1'b1;
                            emit_count = cnt_inc;
                            emit_last  = s_last;
                            state_d    = IDLE;
                        end else begin
                            run_cnt_d = cnt_inc;
                        end
                    end else begin
                        // Close the current run; the new symbol either starts a run or,
                        // on frame end, waits one cycle in PEND for the output register.
                        emit      = 1'b1;
                        run_sym_d = s_data;
                        run_cnt_d = CNT_W'(1);
                        state_d   = s_last ? PEND : RUN;
                    end
                end
            end
            PEND: begin
                if (out_free) begin
                    emit       = 1'b1;
                    emit_count = CNT_W'(1);
                    emit_last  = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        m_valid_d = m_valid_q && !m_ready;
        m_data_d  = m_data_q;
        m_count_d = m_count_q;
        m_last_d  = m_last_q;
        if (emit) begin
            m_valid_d = 1'b1;
            m_data_d  = emit_data;
            m_count_d = emit_count;
            m_last_d  = emit_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            run_sym_q <= '0;
            run_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_sym_q <= run_sym_d;
            run_cnt_q <= run_cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_count = m_count_q;
    assign m_last  = m_last_q;
endmodule

// File: tb/tb_rle_encoder_stream.sv
// Directed bench for rle_encoder_stream: three instances (default, CNT_W=2, ZRL=1)
// share one input stream; each instance's output pairs are collected and compared.
module tb_rle_encoder_stream;
    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_ready;

    logic       s_ready0, s_ready1, s_ready2;
    logic       m_valid0, m_valid1, m_valid2;
    logic [7:0] m_data0, m_data1, m_data2;
    logic [7:0] m_count0, m_count2;
    logic [1:0] m_count1;
    logic       m_last0, m_last1, m_last2;

    int errors = 0;
    int checks = 0;
    int sel = 0;
    logic [31:0] q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    rle_encoder_stream #(.DATA_W(8), .CNT_W(8), .ZRL(0)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
        .m_count(m_count0), .m_last(m_last0));
    rle_encoder_stream #(.DATA_W(8), .CNT_W(2), .ZRL(0)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
        .m_count(m_count1), .m_last(m_last1));
    rle_encoder_stream #(.DATA_W(8), .CNT_W(8), .ZRL(1)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2),
        .m_count(m_count2), .m_last(m_last2));

    function automatic logic [31:0] pk(input logic [7:0] d, input logic [7:0] c, input logic l);
        return {15'd0, d, c, l};
    endfunction

    // Inputs change just after the rising edge, so the falling edge sees what the next edge will.
    always @(negedge clk) begin
        if (!rst && m_ready) begin
            if (m_valid0) q0.push_back(pk(m_data0, m_count0, m_last0));
            if (m_valid1) q1.push_back(pk(m_data1, {6'd0, m_count1}, m_last1));
            if (m_valid2) q2.push_back(pk(m_data2, m_count2, m_last2));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic l);
        logic acc;
        logic rdy;
        acc = 1'b0;
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = (sel == 0) ? s_ready0 : (sel == 1) ? s_ready1 : s_ready2;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        chk({tag, "_accepted"}, {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        m_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic chk_q(input string tag, input int which, input logic [31:0] exp[$]);
        logic [31:0] got[$];
        got = (which == 0) ? q0 : (which == 1) ? q1 : q2;
        chk({tag, "_npairs"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s_pair%0d", tag, i), got[i], exp[i]);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", {31'd0, m_valid0}, 32'd0);
        chk("rst_m_data", {24'd0, m_data0}, 32'd0);
        chk("rst_m_count", {24'd0, m_count0}, 32'd0);
        chk("rst_m_last", {31'd0, m_last0}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready0}, 32'd0);

        // T1: 5,5,5,7(last)
        do_reset();
        sel = 0;
        beat("t1_b0", 8'd5, 1'b0);
        beat("t1_b1", 8'd5, 1'b0);
        beat("t1_b2", 8'd5, 1'b0);
        chk("t1_no_early_pair", {31'd0, m_valid0}, 32'd0);
        beat("t1_b3", 8'd7, 1'b1);
        drain();
        chk_q("t1", 0, '{pk(8'd5, 8'd3, 1'b0), pk(8'd7, 8'd1, 1'b1)});

        // T2: seven 9s with MAX_RUN=3
        do_reset();
        sel = 1;
        for (int i = 0; i < 7; i++) beat($sformatf("t2_b%0d", i), 8'd9, (i == 6));
        drain();
        chk_q("t2", 1, '{pk(8'd9, 8'd3, 1'b0), pk(8'd9, 8'd3, 1'b0), pk(8'd9, 8'd1, 1'b1)});

        // T3: backpressure 1,1,2,2,3(last) with m_ready low for 10 cycles
        do_reset();
        sel = 0;
        m_ready = 1'b0;
        fork
            begin
                beat("t3_b0", 8'd1, 1'b0);
                beat("t3_b1", 8'd1, 1'b0);
                beat("t3_b2", 8'd2, 1'b0);
                beat("t3_b3", 8'd2, 1'b0);
                beat("t3_b4", 8'd3, 1'b1);
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                chk("t3_stall_s_ready", {31'd0, s_ready0}, 32'd0);
                chk("t3_stall_pair", pk(m_data0, m_count0, m_last0), pk(8'd1, 8'd2, 1'b0));
                repeat (4) @(posedge clk);
                #2;
                chk("t3_stable_valid", {31'd0, m_valid0}, 32'd1);
                chk("t3_stable_pair", pk(m_data0, m_count0, m_last0), pk(8'd1, 8'd2, 1'b0));
                m_ready = 1'b1;
            end
        join
        drain();
        chk_q("t3", 0, '{pk(8'd1, 8'd2, 1'b0), pk(8'd2, 8'd2, 1'b0), pk(8'd3, 8'd1, 1'b1)});

        // T4: zero-run-only mode 0,0,0,4,4,0(last)
        do_reset();
        sel = 2;
        beat("t4_b0", 8'd0, 1'b0);
        beat("t4_b1", 8'd0, 1'b0);
        beat("t4_b2", 8'd0, 1'b0);
        beat("t4_b3", 8'd4, 1'b0);
        beat("t4_b4", 8'd4, 1'b0);
        beat("t4_b5", 8'd0, 1'b1);
        drain();
        chk_q("t4", 2, '{pk(8'd0, 8'd3, 1'b0), pk(8'd4, 8'd1, 1'b0),
                         pk(8'd4, 8'd1, 1'b0), pk(8'd0, 8'd1, 1'b1)});

        // T5: mismatch on last 3,3,8(last); the cycle after acceptance is the PEND cycle
        do_reset();
        sel = 0;
        beat("t5_b0", 8'd3, 1'b0);
        beat("t5_b1", 8'd3, 1'b0);
        beat("t5_b2", 8'd8, 1'b1);
        chk("t5_pend_s_ready", {31'd0, s_ready0}, 32'd0);
        chk("t5_pend_out", pk(m_data0, m_count0, m_last0), pk(8'd3, 8'd2, 1'b0));
        @(posedge clk);
        #1;
        chk("t5_next_out", pk(m_data0, m_count0, m_last0), pk(8'd8, 8'd1, 1'b1));
        chk("t5_next_valid", {31'd0, m_valid0}, 32'd1);
        drain();
        chk_q("t5", 0, '{pk(8'd3, 8'd2, 1'b0), pk(8'd8, 8'd1, 1'b1)});

        // T6: reset mid-run drops the run of 6s
        do_reset();
        sel = 0;
        beat("t6_b0", 8'd6, 1'b0);
        beat("t6_b1", 8'd6, 1'b0);
        beat("t6_b2", 8'd6, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_s_ready", {31'd0, s_ready0}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_rst_m_valid", {31'd0, m_valid0}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_idle_m_valid", {31'd0, m_valid0}, 32'd0);
        beat("t6_b3", 8'd2, 1'b1);
        drain();
        chk_q("t6", 0, '{pk(8'd2, 8'd1, 1'b1)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
